// File: rtl/fpu_request_buffer_nbank.sv
// Purpose  : N-bank ring staging store between the memory engine and the FPU column datapath.
//            Read side: memory fills a bank, the FPU reads committed banks row by row.
//            Write side: the FPU writes result rows, memory drains committed banks 8 bytes at a time.
// Latency  : comp_rd_data/comp_rd_vld and drain_data/drain_vld are registered, 1 cycle after the request.
// Backpres.: fill_ready/comp_wr_ready drop when every bank of that side is committed; writes issued
//            then are dropped. A commit into a full side or a release of an empty side is ignored
//            and latched in err.
// Ports    : fill_*      byte-column writes into the current fill bank, fill_done commits it
//            comp_rd_*   row reads from the oldest committed read bank, comp_rd_done releases it
//            comp_wr_*   row writes into the current write bank, comp_wr_done commits it
//            drain_*     byte-column reads from the oldest committed write bank, drain_done releases it
//            err         sticky {drain_done underflow, comp_wr_done overflow,
//                                comp_rd_done underflow, fill_done overflow}
module fpu_request_buffer_nbank #(
  parameter int NUM_BANKS    = 2,
  parameter int BUFFER_DEPTH = 512,
  parameter int COL_WIDTH    = 10,
  localparam int RB = $clog2(BUFFER_DEPTH),
  localparam int GB = $clog2(BUFFER_DEPTH / 8),
  localparam int CB = $clog2(COL_WIDTH),
  localparam int WB = $clog2(COL_WIDTH - 2),
  localparam int PB = $clog2(NUM_BANKS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_wr,
  input  logic [CB-1:0]                fill_col,
  input  logic [GB-1:0]                fill_grp,
  input  logic [63:0]                  fill_data,
  input  logic                         fill_done,
  output logic                         fill_ready,
  input  logic                         comp_rd_en,
  input  logic [RB-1:0]                comp_rd_row,
  output logic [8*COL_WIDTH-1:0]       comp_rd_data,
  output logic                         comp_rd_vld,
  output logic                         comp_avail,
  input  logic                         comp_rd_done,
  input  logic                         comp_wr_en,
  input  logic [RB-1:0]                comp_wr_row,
  input  logic [8*(COL_WIDTH-2)-1:0]   comp_wr_data,
  input  logic                         comp_wr_done,
  output logic                         comp_wr_ready,
  input  logic                         drain_rd,
  input  logic [WB-1:0]                drain_col,
  input  logic [GB-1:0]                drain_grp,
  output logic [63:0]                  drain_data,
  output logic                         drain_vld,
  output logic                         drain_avail,
  input  logic                         drain_done,
  output logic [3:0]                   err
);

  localparam int              PW    = $clog2(NUM_BANKS);
  localparam int              WCOLS = COL_WIDTH - 2;
  localparam logic [PB-1:0]   FULL  = PB'(NUM_BANKS);
  localparam logic [PW-1:0]   LAST  = PW'(NUM_BANKS - 1);
  localparam logic [CB-1:0]   CMAX  = CB'(COL_WIDTH - 1);

  // Explicit wrap so non power-of-2 bank counts cycle correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0] rd_fill_ptr_q, rd_fill_ptr_d, rd_comp_ptr_q, rd_comp_ptr_d;
  logic [PW-1:0] wr_comp_ptr_q, wr_comp_ptr_d, wr_drain_ptr_q, wr_drain_ptr_d;
  logic [PB-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [3:0]    err_q, err_d;

  logic                   comp_rd_vld_q, drain_vld_q;
  logic [8*COL_WIDTH-1:0] comp_rd_data_q;
  logic [63:0]            drain_data_q;

  logic [COL_WIDTH-1:0][7:0] rd_mem [NUM_BANKS][BUFFER_DEPTH];
  logic [WCOLS-1:0][7:0]     wr_mem [NUM_BANKS][BUFFER_DEPTH];

  // A release is evaluated first so a commit into a full side succeeds when
  // the same cycle also frees a bank.
  logic rd_rel, rd_com, wr_rel, wr_com;
  assign rd_rel = comp_rd_done && (rd_count_q != '0);
  assign rd_com = fill_done && ((rd_count_q != FULL) || rd_rel);
  assign wr_rel = drain_done && (wr_count_q != '0);
  assign wr_com = comp_wr_done && ((wr_count_q != FULL) || wr_rel);

  assign fill_ready    = (rd_count_q != FULL);
  assign comp_avail    = (rd_count_q != '0);
  assign comp_wr_ready = (wr_count_q != FULL);
  assign drain_avail   = (wr_count_q != '0);

  always_comb begin
    rd_fill_ptr_d  = rd_com ? ptr_inc(rd_fill_ptr_q) : rd_fill_ptr_q;
    rd_comp_ptr_d  = rd_rel ? ptr_inc(rd_comp_ptr_q) : rd_comp_ptr_q;
    wr_comp_ptr_d  = wr_com ? ptr_inc(wr_comp_ptr_q) : wr_comp_ptr_q;
    wr_drain_ptr_d = wr_rel ? ptr_inc(wr_drain_ptr_q) : wr_drain_ptr_q;

    rd_count_d = rd_count_q;
    if (rd_com && !rd_rel)      rd_count_d = rd_count_q + PB'(1);
    else if (!rd_com && rd_rel) rd_count_d = rd_count_q - PB'(1);

    wr_count_d = wr_count_q;
    if (wr_com && !wr_rel)      wr_count_d = wr_count_q + PB'(1);
    else if (!wr_com && wr_rel) wr_count_d = wr_count_q - PB'(1);

    err_d = err_q | {drain_done && !wr_rel, comp_wr_done && !wr_com,
                     comp_rd_done && !rd_rel, fill_done && !rd_com};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_fill_ptr_q  <= '0;
      rd_comp_ptr_q  <= '0;
      wr_comp_ptr_q  <= '0;
      wr_drain_ptr_q <= '0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
      err_q          <= '0;
    end else begin
      rd_fill_ptr_q  <= rd_fill_ptr_d;
      rd_comp_ptr_q  <= rd_comp_ptr_d;
      wr_comp_ptr_q  <= wr_comp_ptr_d;
      wr_drain_ptr_q <= wr_drain_ptr_d;
      rd_count_q     <= rd_count_d;
      wr_count_q     <= wr_count_d;
      err_q          <= err_d;
    end
  end

  // Storage is not reset. When a side is full the fill/write pointer aliases
  // the oldest committed bank, so writes are gated by the ready flags.
  always_ff @(posedge clk) begin
    if (fill_wr && fill_ready && (fill_col <= CMAX)) begin
      for (int k = 0; k < 8; k++)
        rd_mem[rd_fill_ptr_q][{fill_grp, 3'(k)}][fill_col] <= fill_data[8*k +: 8];
    end
    if (comp_wr_en && comp_wr_ready)
      wr_mem[wr_comp_ptr_q][comp_wr_row] <= comp_wr_data;
  end

  // Reads use the pre-release pointer, so a same-cycle release cannot change
  // the returned data. Reads without a committed bank still update data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_rd_vld_q  <= 1'b0;
      comp_rd_data_q <= '0;
      drain_vld_q    <= 1'b0;
      drain_data_q   <= '0;
    end else begin
      comp_rd_vld_q <= comp_rd_en && comp_avail;
      if (comp_rd_en)
        comp_rd_data_q <= rd_mem[rd_comp_ptr_q][comp_rd_row];
      drain_vld_q <= drain_rd && drain_avail;
      if (drain_rd) begin
        for (int k = 0; k < 8; k++)
          drain_data_q[8*k +: 8] <= wr_mem[wr_drain_ptr_q][{drain_grp, 3'(k)}][drain_col];
      end
    end
  end

  assign comp_rd_data = comp_rd_data_q;
  assign comp_rd_vld  = comp_rd_vld_q;
  assign drain_data   = drain_data_q;
  assign drain_vld    = drain_vld_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fpu_request_buffer_nbank.sv
module tb_fpu_request_buffer_nbank;
  localparam int NB = 3;
  localparam int BD = 64;
  localparam int CW = 10;
  localparam int WC = CW - 2;

  logic clk, rst;
  logic fill_wr, fill_done, fill_ready;
  logic [3:0] fill_col;
  logic [2:0] fill_grp;
  logic [63:0] fill_data;
  logic comp_rd_en, comp_rd_vld, comp_avail, comp_rd_done;
  logic [5:0] comp_rd_row;
  logic [79:0] comp_rd_data;
  logic comp_wr_en, comp_wr_done, comp_wr_ready;
  logic [5:0] comp_wr_row;
  logic [63:0] comp_wr_data;
  logic drain_rd, drain_vld, drain_avail, drain_done;
  logic [2:0] drain_col, drain_grp;
  logic [63:0] drain_data;
  logic [3:0] err;

  fpu_request_buffer_nbank #(.NUM_BANKS(NB), .BUFFER_DEPTH(BD), .COL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .fill_wr(fill_wr), .fill_col(fill_col), .fill_grp(fill_grp), .fill_data(fill_data),
    .fill_done(fill_done), .fill_ready(fill_ready),
    .comp_rd_en(comp_rd_en), .comp_rd_row(comp_rd_row), .comp_rd_data(comp_rd_data),
    .comp_rd_vld(comp_rd_vld), .comp_avail(comp_avail), .comp_rd_done(comp_rd_done),
    .comp_wr_en(comp_wr_en), .comp_wr_row(comp_wr_row), .comp_wr_data(comp_wr_data),
    .comp_wr_done(comp_wr_done), .comp_wr_ready(comp_wr_ready),
    .drain_rd(drain_rd), .drain_col(drain_col), .drain_grp(drain_grp),
    .drain_data(drain_data), .drain_vld(drain_vld), .drain_avail(drain_avail),
    .drain_done(drain_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Behavioural model: byte arrays per bank plus occupancy as FIFO counters.
  logic [7:0] m_rd [NB][BD][CW];
  bit         m_rdk [NB][BD][CW];
  logic [7:0] m_wr [NB][BD][WC];
  bit         m_wrk [NB][BD][WC];
  int m_rcnt, m_rfp, m_rcp, m_wcnt, m_wcp, m_wdp;
  logic [3:0] m_err;
  logic [79:0] e_crd, k_crd;
  logic [63:0] e_dd, k_dd;
  logic e_crv, e_dv;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_rcnt = 0; m_rfp = 0; m_rcp = 0;
    m_wcnt = 0; m_wcp = 0; m_wdp = 0;
    m_err = '0;
    e_crd = '0; k_crd = '1; e_crv = 1'b0;
    e_dd = '0;  k_dd = '1;  e_dv = 1'b0;
  endfunction

  function automatic void model_step();
    bit rrel, rcom, wrel, wcom;
    if (comp_rd_en) begin
      for (int c = 0; c < CW; c++) begin
        e_crd[8*c +: 8] = m_rd[m_rcp][comp_rd_row][c];
        k_crd[8*c +: 8] = m_rdk[m_rcp][comp_rd_row][c] ? 8'hFF : 8'h00;
      end
    end
    e_crv = comp_rd_en && (m_rcnt > 0);
    if (drain_rd) begin
      for (int k = 0; k < 8; k++) begin
        e_dd[8*k +: 8] = m_wr[m_wdp][int'(drain_grp)*8 + k][drain_col];
        k_dd[8*k +: 8] = m_wrk[m_wdp][int'(drain_grp)*8 + k][drain_col] ? 8'hFF : 8'h00;
      end
    end
    e_dv = drain_rd && (m_wcnt > 0);
    if (fill_wr && m_rcnt < NB && int'(fill_col) < CW) begin
      for (int k = 0; k < 8; k++) begin
        m_rd[m_rfp][int'(fill_grp)*8 + k][fill_col] = fill_data[8*k +: 8];
        m_rdk[m_rfp][int'(fill_grp)*8 + k][fill_col] = 1'b1;
      end
    end
    if (comp_wr_en && m_wcnt < NB) begin
      for (int c = 0; c < WC; c++) begin
        m_wr[m_wcp][comp_wr_row][c] = comp_wr_data[8*c +: 8];
        m_wrk[m_wcp][comp_wr_row][c] = 1'b1;
      end
    end
    rrel = comp_rd_done && (m_rcnt > 0);
    rcom = fill_done && ((m_rcnt - int'(rrel)) < NB);
    wrel = drain_done && (m_wcnt > 0);
    wcom = comp_wr_done && ((m_wcnt - int'(wrel)) < NB);
    if (fill_done && !rcom)    m_err[0] = 1'b1;
    if (comp_rd_done && !rrel) m_err[1] = 1'b1;
    if (comp_wr_done && !wcom) m_err[2] = 1'b1;
    if (drain_done && !wrel)   m_err[3] = 1'b1;
    m_rcnt = m_rcnt + int'(rcom) - int'(rrel);
    m_wcnt = m_wcnt + int'(wcom) - int'(wrel);
    if (rcom) m_rfp = (m_rfp + 1) % NB;
    if (rrel) m_rcp = (m_rcp + 1) % NB;
    if (wcom) m_wcp = (m_wcp + 1) % NB;
    if (wrel) m_wdp = (m_wdp + 1) % NB;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("err", 80'(err), 80'(m_err));
      chk("fill_ready", 80'(fill_ready), 80'(m_rcnt != NB));
      chk("comp_avail", 80'(comp_avail), 80'(m_rcnt != 0));
      chk("comp_wr_ready", 80'(comp_wr_ready), 80'(m_wcnt != NB));
      chk("drain_avail", 80'(drain_avail), 80'(m_wcnt != 0));
      chk("comp_rd_vld", 80'(comp_rd_vld), 80'(e_crv));
      chk("drain_vld", 80'(drain_vld), 80'(e_dv));
      chk("comp_rd_data", comp_rd_data & k_crd, e_crd & k_crd);
      chk("drain_data", 80'(drain_data & k_dd), 80'(e_dd & k_dd));
    end
  end

  task automatic clr();
    fill_wr = 0; fill_done = 0; comp_rd_en = 0; comp_rd_done = 0;
    comp_wr_en = 0; comp_wr_done = 0; drain_rd = 0; drain_done = 0;
  endtask

  // Model reads the inputs as they were at the edge, then the bench may drive new ones.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 0; clr();
    fill_col = 0; fill_grp = 0; fill_data = 0; comp_rd_row = 0;
    comp_wr_row = 0; comp_wr_data = 0; drain_col = 0; drain_grp = 0;
    model_reset();
    #3;
    do_reset();
    chk_en = 1;

    chk("rst_fill_ready", 80'(fill_ready), 80'(1));
    chk("rst_comp_wr_ready", 80'(comp_wr_ready), 80'(1));
    chk("rst_comp_avail", 80'(comp_avail), 80'(0));
    chk("rst_drain_avail", 80'(drain_avail), 80'(0));
    chk("rst_err", 80'(err), 80'(0));
    chk("rst_rd_data", comp_rd_data, 80'(0));

    // Fill column 3 of group 0, commit, read row 5.
    fill_wr = 1; fill_col = 3; fill_grp = 0; fill_data = 64'h0706050403020100;
    tick(); clr();
    fill_done = 1; tick(); clr();
    chk("avail_after_commit", 80'(comp_avail), 80'(1));
    comp_rd_en = 1; comp_rd_row = 5; tick(); clr();
    chk("row5_vld", 80'(comp_rd_vld), 80'(1));
    chk("row5_byte3", 80'(comp_rd_data[31:24]), 80'(8'h05));

    // Fill to full, then overflow.
    fill_done = 1; tick(); tick(); clr();
    chk("full_fill_ready", 80'(fill_ready), 80'(0));
    fill_done = 1; tick(); clr();
    chk("overflow_err", 80'(err), 80'(4'b0001));
    fill_wr = 1; fill_col = 3; fill_grp = 0; fill_data = '1;
    tick(); clr();
    comp_rd_en = 1; comp_rd_row = 5; tick(); clr();
    chk("dropped_fill_byte3", 80'(comp_rd_data[31:24]), 80'(8'h05));

    // Full-state simultaneous release + commit.
    fill_done = 1; comp_rd_done = 1; tick(); clr();
    chk("full_swap_err", 80'(err), 80'(4'b0001));
    chk("full_swap_ready", 80'(fill_ready), 80'(0));
    comp_rd_done = 1; tick(); clr();

    // Two committed banks; five swaps each committing a marked bank.
    for (int i = 0; i < 5; i++) begin
      fill_wr = 1; fill_col = 0; fill_grp = 0; fill_data = 64'(8'h40 + i);
      tick(); clr();
      fill_done = 1; comp_rd_done = 1; tick(); clr();
      chk("swap_ready", 80'(fill_ready), 80'(1));
    end
    comp_rd_en = 1; comp_rd_row = 0; tick(); clr();
    chk("swap_order_a", 80'(comp_rd_data[7:0]), 80'(8'h43));
    comp_rd_done = 1; tick(); clr();
    comp_rd_en = 1; comp_rd_row = 0; tick(); clr();
    chk("swap_order_b", 80'(comp_rd_data[7:0]), 80'(8'h44));
    comp_rd_done = 1; tick(); tick(); clr();
    chk("underflow_rd_err", 80'(err), 80'(4'b0011));
    chk("empty_avail", 80'(comp_avail), 80'(0));

    // Write side: row 9 then drain column 2 of group 1.
    comp_wr_en = 1; comp_wr_row = 9; comp_wr_data = 64'h1716151413121110;
    tick(); clr();
    comp_wr_done = 1; tick(); clr();
    drain_rd = 1; drain_col = 2; drain_grp = 1; tick(); clr();
    chk("drain_vld", 80'(drain_vld), 80'(1));
    chk("drain_byte1", 80'(drain_data[15:8]), 80'(8'h12));
    drain_done = 1; tick(); tick(); clr();
    chk("underflow_drain_err", 80'(err), 80'(4'b1011));
    comp_wr_done = 1; repeat (4) tick(); clr();
    chk("overflow_wr_err", 80'(err), 80'(4'b1111));
    chk("full_wr_ready", 80'(comp_wr_ready), 80'(0));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      fill_wr      = ($urandom_range(0, 1) == 1);
      fill_col     = 4'($urandom_range(0, 11));
      fill_grp     = 3'($urandom);
      fill_data    = {$urandom, $urandom};
      fill_done    = ($urandom_range(0, 4) == 0);
      comp_rd_en   = ($urandom_range(0, 1) == 1);
      comp_rd_row  = 6'($urandom);
      comp_rd_done = ($urandom_range(0, 4) == 0);
      comp_wr_en   = ($urandom_range(0, 1) == 1);
      comp_wr_row  = 6'($urandom);
      comp_wr_data = {$urandom, $urandom};
      comp_wr_done = ($urandom_range(0, 4) == 0);
      drain_rd     = ($urandom_range(0, 1) == 1);
      drain_col    = 3'($urandom);
      drain_grp    = 3'($urandom);
      drain_done   = ($urandom_range(0, 4) == 0);
      tick();
    end
    clr();

    // Reset while a drain read is returning.
    do_reset();
    comp_wr_done = 1; tick(); tick(); clr();
    drain_rd = 1; drain_grp = 0; tick(); clr();
    chk("pre_rst_drain_vld", 80'(drain_vld), 80'(1));
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_drain_vld", 80'(drain_vld), 80'(0));
    chk("mid_rst_fill_ready", 80'(fill_ready), 80'(1));
    chk("mid_rst_comp_wr_ready", 80'(comp_wr_ready), 80'(1));
    chk("mid_rst_drain_avail", 80'(drain_avail), 80'(0));
    chk("mid_rst_err", 80'(err), 80'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
